// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: one request at a time, shifted by up to STEP bits per RUN cycle.
// Define SHIFT_SEQUENCER_ROR_EN to make op 11 a rotate right; otherwise op 11 is a logical right shift.
module shift_sequencer #(
    parameter int DATA_W = 16,
    parameter int AMT_W  = 32,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens at a posedge where valid & ready are both high;
    // valid may not depend on ready, and out_valid/out_data hold until the transfer.

    localparam int LW = $clog2(DATA_W);
    localparam int EW = AMT_W + LW;
    localparam logic [LW-1:0] STEP_L = LW'(STEP);

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        op_q, op_nxt, op_in;
    logic [DATA_W-1:0] data_q, data_nxt, load_data, shifted;
    logic [LW-1:0]     rem_q, rem_nxt, eff, step_amt;
    logic [EW-1:0]     amt_ext;
    logic              overshift;

    // Zero-extending by LW bits keeps the >= DATA_W test exact for any AMT_W.
    assign amt_ext   = EW'(in_amt);
    assign overshift = |amt_ext[EW-1:LW];

`ifdef SHIFT_SEQUENCER_ROR_EN
    assign op_in = in_op;
`else
    assign op_in = (in_op == OP_ROR) ? OP_SHR : in_op;
`endif

    always_comb begin
        eff       = amt_ext[LW-1:0];
        load_data = in_data;
        if (op_in != OP_ROR && overshift) begin
            eff       = '0;
            load_data = (op_in == OP_SRA) ? {DATA_W{in_data[DATA_W-1]}} : '0;
        end
    end

    assign step_amt = (rem_q > STEP_L) ? STEP_L : rem_q;

`ifdef SHIFT_SEQUENCER_ROR_EN
    logic [2*DATA_W-1:0] rot;
    assign rot = {data_q, data_q} >> step_amt;
`endif

    always_comb begin
        shifted = data_q >> step_amt;
        case (op_q)
            OP_SHL: shifted = data_q << step_amt;
            OP_SRA: shifted = $signed(data_q) >>> step_amt;
`ifdef SHIFT_SEQUENCER_ROR_EN
            OP_ROR: shifted = rot[DATA_W-1:0];
`endif
            default: shifted = data_q >> step_amt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        data_nxt  = data_q;
        rem_nxt   = rem_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_nxt    = op_in;
                    data_nxt  = load_data;
                    rem_nxt   = eff;
                    state_nxt = (eff == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                data_nxt = shifted;
                rem_nxt  = rem_q - step_amt;
                if (rem_q <= STEP_L) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= OP_SHL;
            data_q <= '0;
            rem_q  <= '0;
        end else begin
            state  <= state_nxt;
            op_q   <= op_nxt;
            data_q <= data_nxt;
            rem_q  <= rem_nxt;
        end
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign out_data  = data_q;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: arithmetic reference model, expected queues, latency and
// literal checks per result, plus backpressure and mid-operation reset scenarios.
module tb_shift_sequencer;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 32;
    localparam int STEP   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [1:0]        in_op = 2'b00;
    logic [DATA_W-1:0] in_data = '0;
    logic [AMT_W-1:0]  in_amt = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic [1:0]        dbg_state;

    shift_sequencer #(.DATA_W(DATA_W), .AMT_W(AMT_W), .STEP(STEP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] lit_q[$];
    int                cyc_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    bit  started = 1'b0;
    bit  seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] map_op(input logic [1:0] op);
`ifdef SHIFT_SEQUENCER_ROR_EN
        return op;
`else
        return (op == 2'b11) ? 2'b01 : op;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] model(input logic [1:0] op, input logic [15:0] d,
                                                input logic [31:0] amt);
        logic [31:0]        w;
        logic signed [31:0] s;
        logic [31:0]        dd;
        w  = {16'h0000, d};
        s  = {{16{d[15]}}, d};
        dd = {d, d};
        case (map_op(op))
            2'b00: begin
                if (amt >= 32'd16) return 16'h0000;
                w = w << amt;
                return w[15:0];
            end
            2'b01: begin
                if (amt >= 32'd16) return 16'h0000;
                w = w >> amt;
                return w[15:0];
            end
            2'b10: begin
                if (amt >= 32'd16) return {16{d[15]}};
                s = s >>> amt;
                return s[15:0];
            end
            default: begin
                dd = dd >> (amt % 32'd16);
                return dd[15:0];
            end
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("in_ready_vs_busy", {31'b0, in_ready}, {31'b0, !busy});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, cyc_q[0]);
                        chk("literal_data", {16'h0, out_data}, {16'h0, lit_q[0]});
                        seen = 1'b1;
                    end
                    chk("model_data", {16'h0, out_data}, {16'h0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(lit_q.pop_front());
                        void'(cyc_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end else if (exp_q.size() > 0 && !seen && cyc == cyc_q[0]) begin
                chk("latency_late", {31'b0, out_valid}, 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+2; returns at posedge+2 of the accept edge.
    task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [31:0] a,
                        input logic [15:0] lit, input int lat);
        int n;
        n = 0;
        in_op = op; in_data = d; in_amt = a; in_valid = 1'b1;
        while (!in_ready && n <= 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (!in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(op, d, a));
        lit_q.push_back(lit);
        cyc_q.push_back(cyc + lat);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic [15:0] bp_lit;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_in_ready_low", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", {16'h0, out_data}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        #1;
        started = 1'b1;

        // op, data, amount, literal result, literal latency (accept edge to out_valid)
        send(2'b01, 16'h0000, 32'hFFFF_0000, 16'h0000, 1);
        send(2'b00, 16'hFFFF, 32'd16,        16'h0000, 1);
        send(2'b01, 16'h8001, 32'd5,         16'h0400, 3);
        send(2'b10, 16'h8000, 32'd15,        16'hFFFF, 5);
        send(2'b10, 16'h8000, 32'h8000_0000, 16'hFFFF, 1);
        send(2'b10, 16'h7FFF, 32'h8000_0000, 16'h0000, 1);
        send(2'b00, 16'h1234, 32'd4,         16'h2340, 2);
        send(2'b00, 16'h00FF, 32'd8,         16'hFF00, 3);
        send(2'b10, 16'hF0F0, 32'd3,         16'hFE1E, 2);
        send(2'b00, 16'hABCD, 32'd0,         16'hABCD, 1);
        send(2'b01, 16'hFFFF, 32'hFFFF_FFFF, 16'h0000, 1);
        send(2'b01, 16'h8000, 32'd15,        16'h0001, 5);
        send(2'b00, 16'h0001, 32'd13,        16'h2000, 5);
        send(2'b10, 16'h4000, 32'd14,        16'h0001, 5);
`ifdef SHIFT_SEQUENCER_ROR_EN
        send(2'b11, 16'h0001, 32'd17,        16'h8000, 2);
        send(2'b11, 16'h1234, 32'd4,         16'h4123, 2);
        send(2'b11, 16'h8421, 32'hFFFF_FFFF, 16'h0843, 5);
`else
        send(2'b11, 16'h0001, 32'd17,        16'h0000, 1);
        send(2'b11, 16'h1234, 32'd4,         16'h0123, 2);
        send(2'b11, 16'h8421, 32'hFFFF_FFFF, 16'h0000, 1);
`endif
        wait_drain();

        // Backpressure: hold the result 5 cycles with a competing request pending.
        out_ready = 1'b0;
        bp_lit = 16'h0400;
        send(2'b01, 16'h8001, 32'd5, bp_lit, 3);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("bp_reach_done", {31'b0, out_valid}, 32'd1);
        in_op = 2'b00; in_data = 16'h0003; in_amt = 32'd2; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
            chk("bp_hold_data", {16'h0, out_data}, {16'h0, bp_lit});
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk); #2;
        end
        out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_after_hs_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_after_hs_ready", {31'b0, in_ready}, 32'd1);
        exp_q.push_back(model(2'b00, 16'h0003, 32'd2));
        lit_q.push_back(16'h000C);
        cyc_q.push_back(cyc + 2);
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("bp_new_accepted", {31'b0, busy}, 32'd1);
        wait_drain();

        // Reset mid-operation: SHL by 12 accepted at T, rst sampled at T+2.
        send(2'b00, 16'h0F0F, 32'd12, 16'hF000, 4);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #2;
        exp_q.delete(); lit_q.delete(); cyc_q.delete();
        seen = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_out_data", {16'h0, out_data}, 32'd0);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        repeat (8) @(posedge clk);
        #2;
        send(2'b01, 16'hF000, 32'd12, 16'h000F, 4);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
